// File: rtl/pmem_line_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pmem_line_responder_if : 256-bit physical-memory line bus          |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pmem_line_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic         pm_error;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata, pm_error
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata, pm_error
    );
endinterface
`default_nettype wire

// File: rtl/pmem_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pmem_line_responder : fixed-latency 256-bit line memory responder  |
// | Optional PMEM_RESP_STALL_EN adds 0..3 LFSR-driven stall cycles.    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pmem_line_responder #(
    parameter int LINES   = 256,
    parameter int LATENCY = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pmem_line_responder_if.slave  bus
);
    localparam int AW = $clog2(LINES);
    localparam int CW = $clog2(LATENCY + 4) + 1;
    localparam logic [CW-1:0] C_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_write;
    logic [31:0]   r_addr;
    logic [255:0]  r_wdata;
    logic          r_oor;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_err;
    logic [255:0]  r_rdata;
    logic [255:0]  mem [LINES];

    logic          w_accept;
    logic          w_both;
    logic          w_mismatch;
    logic          w_err_next;
    logic          w_in_oor;
    logic          w_oor_sel;
    logic [AW-1:0] w_idx;
    logic [CW-1:0] w_stall;

    assign w_in_oor = ({5'b0, bus.pmem_address[31:5]} >= 32'(LINES));

`ifdef PMEM_RESP_STALL_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; the pre-advance value sets the stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall = CW'(r_lfsr[1:0]);
`else
    assign w_stall = '0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_accept     = 1'b0;
        w_err_next   = 1'b0;
        w_oor_sel    = r_oor;
        w_idx        = r_addr[5 +: AW];
        w_both       = bus.pmem_read & bus.pmem_write;
        w_mismatch   = (bus.pmem_read != ~r_write) || (bus.pmem_write != r_write) ||
                       (bus.pmem_address != r_addr);
        case (r_state)
            S_IDLE: begin
                // In IDLE the incoming request is what enters RESP when LATENCY is 1.
                w_oor_sel = w_in_oor;
                w_idx     = bus.pmem_address[5 +: AW];
                if (w_both) begin
                    w_err_next = 1'b1;
                end else if (bus.pmem_read || bus.pmem_write) begin
                    w_accept     = 1'b1;
                    w_count_next = C_LOAD + w_stall;
                    w_state_next = (w_count_next == '0) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                w_err_next   = w_mismatch;
                w_count_next = r_count - CW'(1);
                if (w_count_next == '0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_oor   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_err   <= w_err_next || ((w_state_next == S_RESP) && w_oor_sel);
            r_rdata <= ((w_state_next == S_RESP) && !w_oor_sel) ? mem[w_idx] : '0;
            if (w_accept) begin
                r_write <= bus.pmem_write;
                r_addr  <= bus.pmem_address;
                r_wdata <= bus.pmem_wdata;
                r_oor   <= w_in_oor;
            end
        end
    end

    // Commit at the edge closing RESP so any later read observes the new line.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_RESP) && r_write && !r_oor) begin
            mem[r_addr[5 +: AW]] <= r_wdata;
        end
    end

    assign bus.pmem_resp  = (r_state == S_RESP);
    assign bus.pmem_rdata = r_rdata;
    assign bus.pm_error   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_pmem_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pmem_line_responder : randomized bench with cycle scoreboard    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pmem_line_responder;
`ifdef PMEM_RESP_STALL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 10;
`endif
    localparam int NLINES = 256;
    localparam logic [255:0] C_PAT =
        256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    pmem_line_responder_if bus();

    pmem_line_responder #(.LINES(NLINES), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected outputs keyed by absolute cycle number.
    bit           exp_resp [int];
    bit           exp_err  [int];
    logic [255:0] exp_rd   [int];
    logic [255:0] mdl      [int];
    int           last_resp_cyc = -1;
    logic [255:0] last_rdata;
    logic         last_err;

`ifdef PMEM_RESP_STALL_EN
    logic [7:0] lfsr_m = 8'hA5;
`endif

    function automatic int next_stall();
`ifdef PMEM_RESP_STALL_EN
        int s;
        s = int'(lfsr_m[1:0]);
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        return s;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
`ifdef PMEM_RESP_STALL_EN
        lfsr_m = 8'hA5;
`endif
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("resp", 256'(bus.pmem_resp), 256'(exp_resp.exists(cyc)));
            check("pm_error", 256'(bus.pm_error), 256'(exp_err.exists(cyc)));
            if (exp_rd.exists(cyc)) check("rdata", bus.pmem_rdata, exp_rd[cyc]);
            if (bus.pmem_resp === 1'b1) begin
                last_resp_cyc = cyc;
                last_rdata    = bus.pmem_rdata;
                last_err      = bus.pm_error;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lat_pin(input string name, input int obs);
`ifdef PMEM_RESP_STALL_EN
        check(name, 256'(obs >= 2 && obs <= 5), 256'(1));
`else
        check(name, 256'(obs), 256'(10));
`endif
    endtask

    // One transaction, timed purely by the model; the DUT is never read here.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                       input bit glitch, output int n, output int lat);
        int idx;
        bit oor;
        n   = cyc;
        lat = LAT + next_stall();
        oor = (addr[31:5] >= NLINES);
        idx = int'(addr[12:5]);
        last_resp_cyc = -1;
        bus.pmem_read    = !wr;
        bus.pmem_write   = wr;
        bus.pmem_address = addr;
        bus.pmem_wdata   = data;
        exp_resp[n + lat] = 1'b1;
        if (oor) exp_err[n + lat] = 1'b1;
        if (!wr) begin
            if (oor) exp_rd[n + lat] = '0;
            else if (mdl.exists(idx)) exp_rd[n + lat] = mdl[idx];
        end else if (!oor) begin
            mdl[idx] = data;
        end
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (glitch && lat >= 3 && k == 2) begin
                bus.pmem_address = addr ^ 32'h0000_00C0;
                exp_err[n + 3] = 1'b1;
            end
            if (k == 3) bus.pmem_address = addr;
        end
        tick();
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
    endtask

    task automatic both_high();
        bus.pmem_read  = 1'b1;
        bus.pmem_write = 1'b1;
        exp_err[cyc + 1] = 1'b1;
        tick();
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
    endtask

    initial begin
        int n;
        int lat;
        int rst_at;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        repeat (3) tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_resp", 256'(bus.pmem_resp), 256'(0));
        check("reset_err", 256'(bus.pm_error), 256'(0));
        check("reset_rdata", bus.pmem_rdata, 256'(0));
        tick();

        // Directed write / read of line 2 through two aliases.
        txn(1'b1, 32'h0000_0040, C_PAT, 1'b0, n, lat);
        lat_pin("wr_latency", last_resp_cyc - n);
        txn(1'b0, 32'h0000_005C, '0, 1'b0, n, lat);
        check("rd_5c_data", last_rdata, C_PAT);

        // Both requests at once: error only, no response for 20 cycles.
        both_high();
        repeat (20) tick();

        // Address changes mid-flight; latched address still serves the read.
        txn(1'b0, 32'h0000_0040, '0, 1'b1, n, lat);
        lat_pin("glitch_latency", last_resp_cyc - n);
        check("glitch_data", last_rdata, C_PAT);

        // Out-of-range read and write.
        txn(1'b0, 32'h0000_2000, '0, 1'b0, n, lat);
        check("oor_rdata", last_rdata, 256'(0));
        check("oor_err_with_resp", 256'(last_err), 256'(1));
        txn(1'b1, 32'h0000_2000, {8{32'hFFFF_FFFF}}, 1'b0, n, lat);
        txn(1'b0, 32'h0000_0040, '0, 1'b0, n, lat);
        check("oor_write_dropped", last_rdata, C_PAT);

        // Randomized mix of reads, writes, range errors and protocol errors.
        for (int t = 0; t < 120; t++) begin
            int r;
            int line;
            bit wr;
            logic [31:0] addr;
            r    = $urandom_range(0, 9);
            line = $urandom_range(0, 15);
            if (r == 0) begin
                both_high();
            end else begin
                addr = (32'(line) << 5) | 32'($urandom_range(0, 31));
                if (r == 1) addr = addr | (32'h0000_2000 << $urandom_range(0, 18));
                wr = $urandom_range(0, 1) == 1;
                if (!wr && r != 1 && !mdl.exists(line)) wr = 1'b1;
                txn(wr, addr, {8{$urandom()}}, $urandom_range(0, 5) == 0, n, lat);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset during a write to line 3 aborts it.
        txn(1'b1, 32'h0000_0060, 256'h5, 1'b0, n, lat);
        n      = cyc;
        lat    = LAT + next_stall();
        rst_at = (lat > 4) ? 4 : 1;
        bus.pmem_write   = 1'b1;
        bus.pmem_address = 32'h0000_0060;
        bus.pmem_wdata   = 256'hDEAD_BEEF;
        repeat (rst_at) tick();
        rst = 1'b1;
        bus.pmem_write = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        tick();

`ifdef PMEM_RESP_STALL_EN
        // Back-to-back reads after reseed; first latencies follow A5 -> 4A -> 95.
        for (int t = 0; t < 64; t++) begin
            txn(1'b0, 32'h0000_0060, '0, 1'b0, n, lat);
            check("stall_range", 256'((last_resp_cyc - n) >= 2 && (last_resp_cyc - n) <= 5), 256'(1));
            if (t == 0) check("stall_lat0", 256'(last_resp_cyc - n), 256'(3));
            if (t == 1) check("stall_lat1", 256'(last_resp_cyc - n), 256'(4));
            if (t == 2) check("stall_lat2", 256'(last_resp_cyc - n), 256'(3));
            if (t == 0) check("line3_after_reset", last_rdata, 256'h5);
        end
`else
        txn(1'b0, 32'h0000_0060, '0, 1'b0, n, lat);
        check("line3_after_reset", last_rdata, 256'h5);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pmem_line_responder.md
# pmem_line_responder

Synthesizable responder for the 256-bit physical-memory line interface driven by the `mp3` core's `pmem_*` ports. It stores `LINES` cache lines, accepts one read or write request at a time, and returns a single-cycle `pmem_resp` after a fixed latency. It replaces the behavioural physical memory in benches and FPGA builds, and flags protocol violations on `pm_error`.

## Interface
- `LINES`, 256, number of 32-byte lines stored. Power of two, ≥ 2.
- `LATENCY`, 10, cycles from request acceptance to `pmem_resp`. Must be ≥ 1.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pmem_read`  in  1  read request; held by the initiator until `pmem_resp`.
- `pmem_write`  in  1  write request; held by the initiator until `pmem_resp`.
- `pmem_address`  in  32  byte address. Line index is `address[5+log2(LINES)-1:5]`; bits [4:0] are ignored.
- `pmem_wdata`  in  256  write line; stable while `pmem_write` is high.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `pmem_rdata`  out  256  read line; valid only in the `pmem_resp` cycle of a read.
- `pm_error`  out  1  one-cycle protocol/range error pulse.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- **IDLE**
  - If exactly one of `pmem_read` / `pmem_write` is high: latch command, address, and wdata; load counter with `LATENCY-1` (plus extra stall, see Configuration).
  - Then go to RESP if the count is 0, else to BUSY.
  - If both are high: pulse `pm_error` the next cycle, stay in IDLE, start no transaction.
- **BUSY**
  - Decrement the counter each cycle; go to RESP when it reaches 0.
  - If `pmem_read`, `pmem_write`, or `pmem_address` differ from the latched values, pulse `pm_error` for one cycle. The transaction continues using the latched values.
- **RESP**
  - `pmem_resp`=1.
  - Read: `pmem_rdata` holds the registered line content.
  - Write: the line is updated at the clock edge ending the RESP cycle.
  - Next state is IDLE.
- **Range check:** if `address[31:5] >= LINES`:
  - `pm_error` pulses in the RESP cycle.
  - The response is still given.
  - A read returns all zeros; a write is dropped.
- **Back-to-back requests:** a request still high in the cycle after RESP is accepted as a new transaction. The initiator must drop the request in the cycle it observes `pmem_resp`.
- **Read-after-write** to the same line returns the new data, because the write commits before any later RESP.
- **Memory contents:** not cleared by `rst`; undefined until written.

## Timing
- Request first high in cycle N while in IDLE → `pmem_resp` high in cycle N+`LATENCY` (no stall), for exactly one cycle.
- Throughput: one transaction per `LATENCY`+1 cycles.
- Reset values: `pmem_resp`=0, `pmem_rdata`=0, `pm_error`=0, counter=0, state IDLE.
- Reset mid-BUSY or in RESP: abort the transaction, drop any pending write, produce no resp. Reset has priority over all other events.
- `pm_error` and `pmem_resp` may be high in the same cycle (range error).

## Configuration
- `PMEM_RESP_STALL_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is reset to 8'hA5 and advances once per accepted request.
  - Its bits [1:0] (0–3) are added to the loaded count, so latency is `LATENCY`..`LATENCY`+3. The value used is the one before the advance.
- Not defined: no LFSR; latency is exactly `LATENCY`.

## Test plan
- Reset, then write 256'h0123…CDEF to address 32'h0000_0040 → `pmem_resp` exactly 10 cycles after request, one cycle wide. A subsequent read of 32'h0000_005C returns the same line.
- `pmem_read` and `pmem_write` high together in IDLE → `pm_error` one cycle, no `pmem_resp` within 20 cycles.
- Read of 32'h0000_0040, with address changed to 32'h0000_0080 in BUSY → `pm_error` pulse. Response still arrives at the original latency with line 2's data.
- Read of address 32'h0000_2000 (line 256, LINES=256) → `pmem_resp` and `pm_error` together, `pmem_rdata`=0. A write there leaves lines 0–255 unchanged.
- Assert `rst` 4 cycles into a write to line 3 (previously 256'h5) → no resp; line 3 still reads 256'h5.
- With `PMEM_RESP_STALL_EN`, 64 back-to-back reads at LATENCY=2 → every latency in 2..5, matching the reference LFSR sequence from seed 8'hA5.
